// File: rtl/caesar_pipe_nlane_if.sv
// Valid/ready beat bundle for the multi-lane Caesar shift engine.
// master feeds beats and backpressure; slave is the engine itself.
interface caesar_pipe_nlane_if #(
    parameter int LANES = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [8*LANES-1:0] in_data;
    logic [4:0]         in_key;
    logic               in_mode;
    logic               in_shift_en;
    logic               out_valid;
    logic               out_ready;
    logic [8*LANES-1:0] out_data;
    logic [LANES-1:0]   out_alpha;

    modport master (
        output in_valid,
        output in_data,
        output in_key,
        output in_mode,
        output in_shift_en,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_alpha
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_key,
        input  in_mode,
        input  in_shift_en,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_alpha
    );
endinterface

// File: rtl/caesar_pipe_nlane.sv
// Two-stage LANES-wide Caesar shift engine with valid/ready backpressure.
// Define CAESAR_STATS_EN to add the saturating alpha_count output.
module caesar_pipe_nlane #(
    parameter int LANES = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef CAESAR_STATS_EN
    output logic [31:0] alpha_count,
`endif
    caesar_pipe_nlane_if.slave bus
);
    localparam int         ALPHA_N = 26;
    localparam logic [4:0] KMOD    = 5'(ALPHA_N);

    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    logic [LANES-1:0][ALPHA_N-1:0] c1_oh;
    logic [LANES-1:0]              c1_alpha;
    logic [LANES-1:0]              c1_upper;
    logic [4:0]                    c1_key;
    logic [7:0]                    ch;

    always_comb begin
        ch       = 8'd0;
        c1_oh    = '0;
        c1_alpha = '0;
        c1_upper = '0;
        for (int i = 0; i < LANES; i++) begin
            ch = bus.in_data[8*i +: 8];
            unique case (1'b1)
                (ch >= 8'd65 && ch <= 8'd90): begin
                    c1_upper[i] = 1'b1;
                    c1_alpha[i] = 1'b1;
                    c1_oh[i]    = ALPHA_N'(1) << (ch - 8'd65);
                end
                (ch >= 8'd97 && ch <= 8'd122): begin
                    c1_alpha[i] = 1'b1;
                    c1_oh[i]    = ALPHA_N'(1) << (ch - 8'd97);
                end
                default: ;
            endcase
        end
    end

    assign c1_key = (bus.in_key >= KMOD) ? bus.in_key - KMOD
                                         : bus.in_key;

    logic [LANES-1:0][7:0]         s1_data;
    logic [LANES-1:0][ALPHA_N-1:0] s1_oh;
    logic [LANES-1:0]              s1_alpha;
    logic [LANES-1:0]              s1_upper;
    logic [4:0]                    s1_key;
    logic                          s1_mode;
    logic                          s1_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_oh    <= '0;
            s1_alpha <= '0;
            s1_upper <= '0;
            s1_key   <= '0;
            s1_mode  <= 1'b0;
            s1_en    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data  <= bus.in_data;
                s1_oh    <= c1_oh;
                s1_alpha <= c1_alpha;
                s1_upper <= c1_upper;
                s1_key   <= c1_key;
                s1_mode  <= bus.in_mode;
                s1_en    <= bus.in_shift_en;
            end
        end
    end

    logic [LANES-1:0][7:0] c2_data;
    logic [LANES-1:0]      c2_alpha;
    logic [2*ALPHA_N-1:0]  dbl;
    logic [ALPHA_N-1:0]    rot;
    logic [4:0]            idx;

    // Doubling the one-hot turns the wrap-around rotate into a plain shift.
    always_comb begin
        c2_data  = '0;
        c2_alpha = '0;
        dbl      = '0;
        rot      = '0;
        idx      = '0;
        for (int i = 0; i < LANES; i++) begin
            dbl = {s1_oh[i], s1_oh[i]};
            if (s1_mode)
                rot = ALPHA_N'(dbl >> s1_key);
            else
                rot = ALPHA_N'((dbl << s1_key) >> ALPHA_N);
            idx = '0;
            for (int j = 0; j < ALPHA_N; j++) begin
                if (rot[j])
                    idx = 5'(j);
            end
            if (s1_en && s1_alpha[i]) begin
                c2_data[i]  = (s1_upper[i] ? 8'd65 : 8'd97)
                            + {3'b000, idx};
                c2_alpha[i] = 1'b1;
            end else begin
                c2_data[i]  = s1_data[i];
            end
        end
    end

    logic [LANES-1:0][7:0] s2_data;
    logic [LANES-1:0]      s2_alpha;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_alpha <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data  <= c2_data;
                s2_alpha <= c2_alpha;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_alpha = s2_alpha;

`ifdef CAESAR_STATS_EN
    logic [5:0]  pc;
    logic [32:0] sum;

    always_comb begin
        pc = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s2_alpha[i])
                pc = pc + 6'd1;
        end
    end

    assign sum = {1'b0, alpha_count} + 33'(pc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            alpha_count <= '0;
        else if (s2_valid && bus.out_ready)
            alpha_count <= sum[32] ? '1 : sum[31:0];
    end
`endif
endmodule

// File: tb/tb_caesar_pipe_nlane.sv
// Directed self-checking bench for caesar_pipe_nlane (LANES=4).
// Lane 0 holds the first character of each 4-char string.
module tb_caesar_pipe_nlane;
    logic clk = 1'b0;
    logic rst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    caesar_pipe_nlane_if #(.LANES(4)) bus ();

`ifdef CAESAR_STATS_EN
    logic [31:0] alpha_count;
`endif

    caesar_pipe_nlane #(.LANES(4)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef CAESAR_STATS_EN
        .alpha_count (alpha_count),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    function automatic logic [31:0] str4(input logic [31:0] s);
        return {s[7:0], s[15:8], s[23:16], s[31:24]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d,
                         input logic [4:0] k, input logic m,
                         input logic e);
        bus.in_valid    = v;
        bus.in_data     = d;
        bus.in_key      = k;
        bus.in_mode     = m;
        bus.in_shift_en = e;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_data !== 32'h0)
            $display("FAIL rst_out_data got=%h exp=0", bus.out_data);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_alpha !== 4'h0)
            $display("FAIL rst_out_alpha got=%b exp=0", bus.out_alpha);
        else pass_cnt++;
        #10;
        rst = 1'b1;
        step();
        total_cnt++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL rst_release got=%b%b exp=10",
                     bus.in_ready, bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        drive(1'b1, str4("Hell"), 5'd3, 1'b0, 1'b1);
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL basic_ready got=%b exp=1", bus.in_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL basic_latency1 got=%b exp=0", bus.out_valid);
        else pass_cnt++;
        drive(1'b1, str4("o, W"), 5'd3, 1'b0, 1'b1);
        step();
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== str4("Khoo"))
            $display("FAIL basic_b0 got=%b/%h exp=1/%h",
                     bus.out_valid, bus.out_data, str4("Khoo"));
        else pass_cnt++;
        total_cnt++;
        if (bus.out_alpha !== 4'b1111)
            $display("FAIL basic_b0_alpha got=%b exp=1111", bus.out_alpha);
        else pass_cnt++;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== str4("r, Z"))
            $display("FAIL basic_b1 got=%b/%h exp=1/%h",
                     bus.out_valid, bus.out_data, str4("r, Z"));
        else pass_cnt++;
        total_cnt++;
        if (bus.out_alpha !== 4'b1001)
            $display("FAIL basic_b1_alpha got=%b exp=1001", bus.out_alpha);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL basic_drain got=%b exp=0", bus.out_valid);
        else pass_cnt++;
`ifdef CAESAR_STATS_EN
        total_cnt++;
        if (alpha_count !== 32'd6)
            $display("FAIL stats_count got=%0d exp=6", alpha_count);
        else pass_cnt++;
`endif
    endtask

    task automatic test_decrypt();
        drive(1'b1, str4("aAzZ"), 5'd1, 1'b1, 1'b1);
        step();
        drive(1'b1, str4("aAzZ"), 5'd27, 1'b1, 1'b1);
        step();
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== str4("zZyY")
            || bus.out_alpha !== 4'b1111)
            $display("FAIL dec_key1 got=%h/%b exp=%h/1111",
                     bus.out_data, bus.out_alpha, str4("zZyY"));
        else pass_cnt++;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== str4("zZyY")
            || bus.out_alpha !== 4'b1111)
            $display("FAIL dec_key27 got=%h/%b exp=%h/1111",
                     bus.out_data, bus.out_alpha, str4("zZyY"));
        else pass_cnt++;
        step();
    endtask

    task automatic run_table(input string name,
                             input logic [31:0] din [5],
                             input logic [4:0]  key [5],
                             input logic        md  [5],
                             input logic        en  [5],
                             input logic [31:0] exp [5],
                             input logic [3:0]  expa[5],
                             input int          n);
        for (int c = 0; c <= n; c++) begin
            if (c < n)
                drive(1'b1, din[c], key[c], md[c], en[c]);
            else
                drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
            step();
            if (c >= 1) begin
                total_cnt++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== exp[c-1]
                    || bus.out_alpha !== expa[c-1])
                    $display("FAIL %s_%0d got=%b/%h/%b exp=1/%h/%b",
                             name, c - 1, bus.out_valid, bus.out_data,
                             bus.out_alpha, exp[c-1], expa[c-1]);
                else pass_cnt++;
            end
        end
        step();
    endtask

    task automatic test_passthru();
        logic [31:0] din [5];
        logic [4:0]  key [5];
        logic        md  [5];
        logic        en  [5];
        logic [31:0] exp [5];
        logic [3:0]  expa[5];
        din[0] = str4("Ab{@"); key[0] = 5'd5;  en[0] = 1'b0;
        exp[0] = str4("Ab{@"); expa[0] = 4'b0000;
        din[1] = {8'd123, 8'd96, 8'd91, 8'd64}; key[1] = 5'd3; en[1] = 1'b1;
        exp[1] = {8'd123, 8'd96, 8'd91, 8'd64}; expa[1] = 4'b0000;
        din[2] = {8'h41, 8'hC1, 8'hFF, 8'h00}; key[2] = 5'd3; en[2] = 1'b1;
        exp[2] = {8'h44, 8'hC1, 8'hFF, 8'h00}; expa[2] = 4'b1000;
        din[3] = str4("QzQz"); key[3] = 5'd0;  en[3] = 1'b1;
        exp[3] = str4("QzQz"); expa[3] = 4'b1111;
        din[4] = str4("QzQz"); key[4] = 5'd26; en[4] = 1'b1;
        exp[4] = str4("QzQz"); expa[4] = 4'b1111;
        for (int i = 0; i < 5; i++) md[i] = 1'b0;
        run_table("pass", din, key, md, en, exp, expa, 5);
    endtask

    task automatic test_key_switch();
        logic [31:0] din [5];
        logic [4:0]  key [5];
        logic        md  [5];
        logic        en  [5];
        logic [31:0] exp [5];
        logic [3:0]  expa[5];
        for (int i = 0; i < 5; i++) begin
            din[i] = str4("aaaa"); md[i] = 1'b0; en[i] = 1'b1;
            key[i] = 5'd0; exp[i] = 32'h0; expa[i] = 4'b1111;
        end
        key[0] = 5'd1; exp[0] = str4("bbbb");
        key[1] = 5'd2; exp[1] = str4("cccc");
        key[2] = 5'd3; exp[2] = str4("dddd");
        run_table("key", din, key, md, en, exp, expa, 3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] bp_in  [6];
        logic [31:0] bp_exp [6];
        int sent;
        int got;
        logic acc;
        logic take;
        bp_in[0] = str4("abcd"); bp_exp[0] = str4("bcde");
        bp_in[1] = str4("efgh"); bp_exp[1] = str4("fghi");
        bp_in[2] = str4("ijkl"); bp_exp[2] = str4("jklm");
        bp_in[3] = str4("mnop"); bp_exp[3] = str4("nopq");
        bp_in[4] = str4("qrst"); bp_exp[4] = str4("rstu");
        bp_in[5] = str4("uvwx"); bp_exp[5] = str4("vwxy");
        sent = 0;
        got  = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            if (c == 8) begin
                total_cnt++;
                if (sent !== 2)
                    $display("FAIL bp_accepted got=%0d exp=2", sent);
                else pass_cnt++;
                bus.out_ready = 1'b1;
            end
            if (sent < 6)
                drive(1'b1, bp_in[sent], 5'd1, 1'b0, 1'b1);
            else
                drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
            #1;
            acc  = bus.in_ready && bus.in_valid;
            take = bus.out_valid && bus.out_ready;
            if (c >= 2 && c < 8) begin
                total_cnt++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1
                    || bus.out_data !== bp_exp[0])
                    $display("FAIL bp_hold_%0d got=%b/%b/%h exp=0/1/%h",
                             c, bus.in_ready, bus.out_valid,
                             bus.out_data, bp_exp[0]);
                else pass_cnt++;
            end
            if (take) begin
                total_cnt++;
                if (bus.out_data !== bp_exp[got])
                    $display("FAIL bp_order_%0d got=%h exp=%h",
                             got, bus.out_data, bp_exp[got]);
                else pass_cnt++;
                got++;
            end
            if (acc)
                sent++;
            step();
        end
        total_cnt++;
        if (got !== 6 || sent !== 6)
            $display("FAIL bp_drain got=%0d/%0d exp=6/6", got, sent);
        else pass_cnt++;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL bp_no_dup got=%b exp=0", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(1'b1, str4("abcd"), 5'd1, 1'b0, 1'b1);
        step();
        drive(1'b1, str4("efgh"), 5'd1, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
            $display("FAIL mid_full got=%b%b exp=10",
                     bus.out_valid, bus.in_ready);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0
            || bus.out_alpha !== 4'h0)
            $display("FAIL mid_async got=%b/%h/%b exp=0/0/0",
                     bus.out_valid, bus.out_data, bus.out_alpha);
        else pass_cnt++;
`ifdef CAESAR_STATS_EN
        total_cnt++;
        if (alpha_count !== 32'd0)
            $display("FAIL mid_stats got=%0d exp=0", alpha_count);
        else pass_cnt++;
`endif
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL mid_in_ready got=%b exp=1", bus.in_ready);
        else pass_cnt++;
        for (int c = 0; c < 4; c++) begin
            step();
            total_cnt++;
            if (bus.out_valid !== 1'b0)
                $display("FAIL mid_stale_%0d got=%b exp=0",
                         c, bus.out_valid);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_decrypt();
        test_passthru();
        test_key_switch();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/caesar_pipe_nlane.md
Name: caesar_pipe_nlane

Overview:
Multi-lane, parametrised Caesar shift engine. It performs alpha classification and one-hot rotation together, and moves data under valid/ready flow control.
- Processes LANES ASCII characters per beat.
- Per-beat key and encrypt/decrypt mode.
- Two-stage pipeline with full backpressure.
- Sits between the byte-stream input framer and the output packer in the encrypter/decrypter datapath.

Parameters:
LANES, 4, characters per beat (1..16)
ALPHA_N, 26, alphabet size for rotation; fixed, not user-tunable

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  engine can accept beat
in_data  input  8*LANES  characters; lane i = bits [8i+7:8i]
in_key  input  5  shift amount, sampled with beat
in_mode  input  1  0 = encrypt (rotate forward), 1 = decrypt (rotate backward)
in_shift_en  input  1  0 = pass all lanes unchanged
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat
out_data  output  8*LANES  transformed characters
out_alpha  output  LANES  per-lane flag, 1 = lane was alphabetic and rotated

Behaviour:
- Reset: rst low clears all valid flags and data registers asynchronously. in_ready=1 after reset; out_valid=0, out_data=0, out_alpha=0.
- Reset mid-operation drops all in-flight beats; nothing is replayed.
- Transfer: a beat moves on a clock edge when valid and ready are both 1. Data is held stable while out_valid=1 and out_ready=0.
- Stage 1 (S1), registered:
  - Per lane: upper = 65..90, lower = 97..122.
  - Index = din-65 or din-97; encoded as a 26-bit one-hot.
  - Key reduced mod 26 (26..31 -> 0..5).
  - Captures the key, mode and shift_en of that beat.
- Stage 2 (S2), registered:
  - One-hot rotated by the effective key: left (toward Z) for encrypt, right for decrypt, wrapping at 26.
  - Result encoded back to ASCII with the original case preserved.
  - Lanes that are non-alpha, or in beats with shift_en=0, output din unchanged; their out_alpha bit = 0.
- Latency: exactly 2 cycles from input handshake to out_valid with out_ready held 1. Throughput is 1 beat/cycle.
- Flow control:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv, combinational from registered state and out_ready only. There is no path from in_valid to in_ready.
- Bubbles collapse: an empty S2 accepts S1 even when out_ready=0.
- Key/mode changes between beats take effect on the next beat only. In-flight beats keep their own captured key.
- Key 0 or key 26: alpha lanes unchanged but out_alpha=1.
- Wrap examples:
  - 'Z', key 1, encrypt -> 'A'.
  - 'a', key 1, decrypt -> 'z'.
- Byte 0x00 and bytes >127 pass through unchanged.

Optional Feature:
Macro CAESAR_STATS_EN.
- Defined: adds output port alpha_count (32 bits). It counts alpha lanes (popcount of out_alpha) on each output handshake.
  - Saturates at 32'hFFFFFFFF.
  - Reset to 0 by rst.
  - Increments only when out_valid and out_ready are both 1.
- Undefined: port and counter absent; all other behaviour is identical.

Test Plan:
- LANES=4, key=3, mode=0, shift_en=1, in_data="Hell" then "o, W" -> outputs "Khoo" then "r, Z". out_alpha 4'b1111 then 4'b1001 (lane 0 = 'o' -> 'r', lane 3 = 'W' -> 'Z'). Each appears 2 cycles after its handshake.
- key=1, mode=1, "aAzZ" -> "zZyY". Same beat with key=27 gives the same result (mod 26).
- shift_en=0, key=5, "Ab{@" -> "Ab{@", out_alpha=0. Boundary bytes 64, 91, 96, 123 pass unchanged with shift_en=1.
- Back-to-back 6 beats with out_ready held 0:
  - Exactly 2 beats are accepted, then in_ready=0.
  - out_data is held stable.
  - Releasing out_ready drains in order with no loss or duplication.
- Key switched every beat (1, 2, 3) on "aaaa" -> outputs "bbbb", "cccc", "dddd".
- rst pulsed low while both stages are valid -> out_valid=0 immediately, in_ready=1 after release, and no stale beat is emitted. With CAESAR_STATS_EN defined, alpha_count=0.
